// File: rtl/sr_wr_pkg.sv
// sr_wr_pkg: shared constants, FIFO entry type and address-width helper for sr_raster_writer
package sr_wr_pkg;
    localparam int PIX_W  = 8;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
    // Addresses are carried at full 32 bits inside the FIFO; the top truncates to AW.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } sr_wr_entry_t;
    function automatic int sr_wr_aw(input int width, input int height);
        return (width * height > 1) ? $clog2(width * height) : 1;
    endfunction
endpackage

// File: rtl/sr_wr_fifo.sv
// sr_wr_fifo: synchronous show-ahead FIFO holding odd-row words
//   clk, rst (sync, active-low)
//   push/din  : write an entry; accepted when not full, or when full with a same-cycle pop
//   pop       : advance head when not empty
//   full/empty: registered-pointer status
//   dout      : head entry (show-ahead)
module sr_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int PW = $clog2(DEPTH);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sr_wr_fifo: DEPTH must be a power of two and at least 2");
    end
    logic [PW:0]  wp_q, wp_d, rp_q, rp_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;
    always_comb begin
        empty   = wp_q == rp_q;
        full    = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wp_d    = wp_q + (PW+1)'(do_push);
        rp_d    = rp_q + (PW+1)'(do_pop);
        dout    = mem_q[rp_q[PW-1:0]];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[PW-1:0]] <= din;
    end
endmodule

// File: rtl/sr_raster_writer.sv
// sr_raster_writer: packs 2x2 upscaled blocks into 32-bit words of the 2W x 2H output frame
//   clk, rst (sync, active-low)
//   in_valid, in1..in4 : one 2x2 block per valid cycle (TL, TR, BL, BR)
//   wr_en, wr_addr, wr_data : registered word write port, leftmost pixel in [7:0]
//   frame_done : pulse with the write of address WIDTH*HEIGHT-1
//   ovf        : sticky, an odd-row word was dropped on a full FIFO
//   SR_WR_CLAMP_EN : when defined, negative pixels are clamped to 0 at capture
module sr_raster_writer
    import sr_wr_pkg::*;
#(
    parameter int WIDTH      = 114,
    parameter int HEIGHT     = 172,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = sr_wr_aw(WIDTH, HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  in1,
    input  logic [PIX_W-1:0]  in2,
    input  logic [PIX_W-1:0]  in3,
    input  logic [PIX_W-1:0]  in4,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              frame_done,
    output logic              ovf
);
    localparam int XW  = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int YW  = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
    localparam int WPR = WIDTH / 2;
    if (WIDTH % 2 != 0) begin : g_bad_width
        $error("sr_raster_writer: WIDTH must be even");
    end
    function automatic logic [PIX_W-1:0] clamp(input logic [PIX_W-1:0] p);
`ifdef SR_WR_CLAMP_EN
        return p[PIX_W-1] ? '0 : p;
`else
        return p;
`endif
    endfunction
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [4*PIX_W-1:0]   h_q, h_d;
    logic                 wr_en_q, wr_en_d, frame_done_q, frame_done_d, ovf_q, ovf_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]    wr_data_q, wr_data_d;
    logic [4*PIX_W-1:0]   c;
    logic                 top_v, pop, full, empty;
    logic [ADDR_W-1:0]    row_base, k, out_addr;
    sr_wr_entry_t         push_e, head;
    sr_wr_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(sr_wr_entry_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (top_v),
        .pop   (pop),
        .din   (push_e),
        .full  (full),
        .empty (empty),
        .dout  (head)
    );
    always_comb begin
        c        = {clamp(in4), clamp(in3), clamp(in2), clamp(in1)};
        top_v    = in_valid && x_q[0];
        row_base = ADDR_W'(y_q) * ADDR_W'(WIDTH);
        k        = ADDR_W'(x_q >> 1);
        push_e   = '{addr: row_base + ADDR_W'(WPR) + k, data: {c[31:16], h_q[31:16]}};
        // FIFO pops only into slots the direct top word leaves free
        pop      = !top_v && !empty;
        out_addr = top_v ? row_base + k : head.addr;
        wr_en_d  = top_v || !empty;
        wr_data_d = !wr_en_d ? wr_data_q : top_v ? {c[15:0], h_q[15:0]} : head.data;
        wr_addr_d = wr_en_d ? AW'(out_addr) : wr_addr_q;
        frame_done_d = wr_en_d && out_addr == ADDR_W'(WIDTH * HEIGHT - 1);
        ovf_d    = ovf_q || (top_v && full && !pop);
        h_d      = (in_valid && !x_q[0]) ? c : h_q;
        x_d      = !in_valid ? x_q : (x_q == XW'(WIDTH - 1)) ? '0 : x_q + 1'b1;
        y_d      = !(in_valid && x_q == XW'(WIDTH - 1)) ? y_q :
                   (y_q == YW'(HEIGHT - 1)) ? '0 : y_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q          <= '0;
            y_q          <= '0;
            h_q          <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            h_q          <= h_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign ovf        = ovf_q;
endmodule

// File: tb/tb_sr_raster_writer.sv
// tb_sr_raster_writer: directed self-checking bench for sr_raster_writer
module tb_sr_raster_writer;
    localparam int W   = 114;
    localparam int H   = 172;
    localparam int WPR = W / 2;
    localparam int NW  = W * H;
    localparam int AW  = 15;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in1 = '0, in2 = '0, in3 = '0, in4 = '0;
    logic          wr_en, frame_done, ovf;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    int            n_checks = 0;
    int            n_pass = 0;
    logic          mon_en = 1'b0;
    int            got_cnt [NW];
    logic [31:0]   got_data [NW];
    int            wr_cnt, fd_cnt, fd_addr, first_addr;
    logic [31:0]   first_data;
    logic          any_seen;

    sr_raster_writer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .in4        (in4),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_en) begin
                wr_cnt = wr_cnt + 1;
                if (!any_seen) begin
                    any_seen   = 1'b1;
                    first_addr = int'(wr_addr);
                    first_data = wr_data;
                end
                if (int'(wr_addr) < NW) begin
                    got_cnt[wr_addr]  = got_cnt[wr_addr] + 1;
                    got_data[wr_addr] = wr_data;
                end
            end
            if (frame_done) begin
                fd_cnt  = fd_cnt + 1;
                fd_addr = int'(wr_addr);
            end
        end
    end

    function automatic logic [7:0] cl(input logic [7:0] p);
`ifdef SR_WR_CLAMP_EN
        return p[7] ? 8'h00 : p;
`else
        return p;
`endif
    endfunction

    function automatic logic [7:0] pix(input int x, input int y, input int i, input int s);
        return 8'((x * 3 + y * 5 + i * 7 + s) & 255);
    endfunction

    function automatic logic [31:0] exp_word(input int a, input int s);
        int r, k, y, b;
        r = a / WPR;
        k = a % WPR;
        y = r / 2;
        b = (r % 2) * 2;
        return {cl(pix(2*k+1, y, b+1, s)), cl(pix(2*k+1, y, b, s)),
                cl(pix(2*k, y, b+1, s)), cl(pix(2*k, y, b, s))};
    endfunction

    function automatic int count_bad(input int s);
        int bad = 0;
        for (int a = 0; a < NW; a++)
            if (got_cnt[a] != 1 || got_data[a] !== exp_word(a, s)) bad++;
        return bad;
    endfunction

    task automatic clear_sb();
        mon_en = 1'b0;
        for (int a = 0; a < NW; a++) begin
            got_cnt[a]  = 0;
            got_data[a] = '0;
        end
        wr_cnt = 0; fd_cnt = 0; fd_addr = -1; first_addr = -1;
        first_data = '0; any_seen = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, b, c, d);
        in_valid = 1'b1;
        in1 = a; in2 = b; in3 = c; in4 = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_frame(input int s, input bit gaps);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (gaps && $urandom_range(0, 15) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
                send(pix(x, y, 0, s), pix(x, y, 1, s), pix(x, y, 2, s), pix(x, y, 3, s));
            end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b1;
        in1 = 8'h11; in2 = 8'h22; in3 = 8'h33; in4 = 8'h44;
        repeat (3) @(negedge clk);
        n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en); else n_pass++;
        n_checks++; if (wr_addr !== '0) $display("FAIL reset_wr_addr got %0d want 0", wr_addr); else n_pass++;
        n_checks++; if (wr_data !== '0) $display("FAIL reset_wr_data got %h want 0", wr_data); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else n_pass++;
        in_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_single_pair();
        bit found = 0;
        logic [31:0] bot = '0;
        do_reset();
        send(8'd1, 8'd2, 8'd3, 8'd4);
        n_checks++; if (wr_en !== 1'b0) $display("FAIL even_no_write got wr_en %b want 0", wr_en); else n_pass++;
        send(8'd5, 8'd6, 8'd7, 8'd8);
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== 15'd0) $display("FAIL top_addr got en %b addr %0d want en 1 addr 0", wr_en, wr_addr); else n_pass++;
        n_checks++; if (wr_data !== 32'h06050201) $display("FAIL top_data got %h want 06050201", wr_data); else n_pass++;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (wr_en && wr_addr == 15'd57) begin
                found = 1;
                bot = wr_data;
            end
        end
        n_checks++; if (!found) $display("FAIL bottom_arrival got none want addr 57 within 6 cycles"); else n_pass++;
        n_checks++; if (bot !== 32'h08070403) $display("FAIL bottom_data got %h want 08070403", bot); else n_pass++;
        @(negedge clk);
        n_checks++; if (wr_en !== 1'b0 || wr_data !== 32'h08070403) $display("FAIL idle_hold got en %b data %h want en 0 data 08070403", wr_en, wr_data); else n_pass++;
    endtask

    task automatic test_full_frame();
        int bad;
        do_reset();
        clear_sb();
        mon_en = 1'b1;
        run_frame(0, 1'b0);
        mon_en = 1'b0;
        bad = count_bad(0);
        n_checks++; if (bad !== 0) $display("FAIL frame_words got %0d bad words want 0", bad); else n_pass++;
        n_checks++; if (wr_cnt !== NW) $display("FAIL frame_count got %0d words want %0d", wr_cnt, NW); else n_pass++;
        n_checks++; if (fd_cnt !== 1) $display("FAIL frame_done_count got %0d want 1", fd_cnt); else n_pass++;
        n_checks++; if (fd_addr !== NW - 1) $display("FAIL frame_done_addr got %0d want %0d", fd_addr, NW - 1); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL frame_ovf got %b want 0", ovf); else n_pass++;
    endtask

    task automatic test_gaps();
        int bad;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            clear_sb();
            mon_en = 1'b1;
            run_frame(f * 41 + 3, 1'b1);
            mon_en = 1'b0;
            bad = count_bad(f * 41 + 3);
            n_checks++; if (bad !== 0) $display("FAIL gaps_words frame %0d got %0d bad words want 0", f, bad); else n_pass++;
            n_checks++; if (first_addr !== 0) $display("FAIL gaps_first_addr frame %0d got %0d want 0", f, first_addr); else n_pass++;
            n_checks++; if (fd_cnt !== 1 || fd_addr !== NW - 1) $display("FAIL gaps_frame_done frame %0d got cnt %0d addr %0d want 1 %0d", f, fd_cnt, fd_addr, NW - 1); else n_pass++;
        end
        n_checks++; if (ovf !== 1'b0) $display("FAIL gaps_ovf got %b want 0", ovf); else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int n = 0; n <= 10 * W + 37; n++)
            send(pix(n % W, n / W, 0, 9), pix(n % W, n / W, 1, 9), pix(n % W, n / W, 2, 9), pix(n % W, n / W, 3, 9));
        do_reset();
        clear_sb();
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (wr_cnt !== 0) $display("FAIL mid_reset_stale got %0d words want 0", wr_cnt); else n_pass++;
        send(8'h10, 8'h20, 8'h30, 8'h40);
        send(8'h50, 8'h60, 8'h70, 8'h7f);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        n_checks++; if (first_addr !== 0) $display("FAIL mid_reset_first_addr got %0d want 0", first_addr); else n_pass++;
        n_checks++; if (first_data !== 32'h60502010) $display("FAIL mid_reset_first_data got %h want 60502010", first_data); else n_pass++;
        n_checks++; if (wr_cnt !== 2 || got_data[WPR] !== 32'h7f704030) $display("FAIL mid_reset_bottom got cnt %0d data %h want 2 7f704030", wr_cnt, got_data[WPR]); else n_pass++;
    endtask

    task automatic test_clamp();
        logic [31:0] exp_top;
        bit found = 0;
`ifdef SR_WR_CLAMP_EN
        exp_top = 32'h7F006400;
`else
        exp_top = 32'h7F8064FB;
`endif
        do_reset();
        send(8'hFB, 8'd100, 8'h80, 8'h01);
        send(8'h80, 8'h7F, 8'hFF, 8'h02);
        n_checks++; if (wr_data !== exp_top) $display("FAIL clamp_top got %h want %h", wr_data, exp_top); else n_pass++;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (wr_en && wr_addr == 15'd57) begin
                found = 1;
                n_checks++;
`ifdef SR_WR_CLAMP_EN
                if (wr_data !== 32'h02000100) $display("FAIL clamp_bottom got %h want 02000100", wr_data); else n_pass++;
`else
                if (wr_data !== 32'h02FF0180) $display("FAIL clamp_bottom got %h want 02ff0180", wr_data); else n_pass++;
`endif
            end
        end
        n_checks++; if (!found) $display("FAIL clamp_bottom_arrival got none want addr 57"); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_full_frame();
        test_gaps();
        test_mid_reset();
        test_clamp();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sr_raster_writer.md
# sr_raster_writer

Downstream stage of the 2x super-resolution LUT engine. Consumes one 2x2 output block per valid cycle (in1/in2 = top-left/top-right, in3/in4 = bottom-left/bottom-right of the upscaled pixel) and packs blocks into 32-bit, 4-pixel words of the 2WIDTH x 2HEIGHT output frame, each with its word address. Even-row words are emitted directly; odd-row words are queued in a small FIFO and drained in idle output slots, so the block sustains one input block per cycle with no backpressure.

## Interface
- WIDTH, 114, input image width in pixels; must be even.
- HEIGHT, 172, input image height in pixels.
- FIFO_DEPTH, 4, odd-row word FIFO entries; power of two, at least 2.
- AW, $clog2(WIDTH*HEIGHT), derived output word-address width. The output frame holds WIDTH*HEIGHT words.
- clk  in  1  sole clock.
- rst  in  1  reset. Synchronous, active-low, with one clock domain.
- in_valid  in  1  in1..in4 hold a valid block for the next raster position.
- in1, in2, in3, in4  in  8 signed  2x2 block pixels.
- wr_en  out  1  wr_addr and wr_data are valid this cycle.
- wr_addr  out  AW  output word address.
- wr_data  out  32  four pixels, leftmost pixel in [7:0].
- frame_done  out  1  one-cycle pulse with the last word of a frame.
- ovf  out  1  sticky flag: an odd-row word was dropped because the FIFO was full.

## Operation
- Position counters x (0..WIDTH-1) and y (0..HEIGHT-1) advance on each in_valid.
  - At x=WIDTH-1, x wraps to 0 and y increments.
  - At (WIDTH-1, HEIGHT-1), both wrap to 0 and the next frame begins.
- Even-x block: in1..in4 are captured into holding registers h1..h4. Nothing is written.
- Odd-x block (pair complete), with k = x>>1 and WPR = WIDTH/2:
  - Top word {in2,in1,h2,h1} goes to address (2y)*WPR+k. It is emitted directly and has priority.
  - Bottom word {in4,in3,h4,h3} goes to address (2y+1)*WPR+k. It is pushed into the FIFO together with its address.
- Pop: in any cycle with no top word and a non-empty FIFO, the head entry is emitted.
- Push and pop in the same cycle are allowed, so occupancy is unchanged.
- Push while full with no pop: the entry is dropped and ovf is set until reset.
- frame_done is asserted with the wr_en whose address is WIDTH*HEIGHT-1. Under normal order this is the last bottom word.
- WIDTH odd: elaboration error via generate $error.

## Timing
- Reset (rst=0 at a clk edge) clears x, y, h1..h4 and FIFO pointers. wr_en, wr_addr, wr_data, frame_done and ovf all read 0.
- Reset mid-frame discards the partial frame and the FIFO contents. The first in_valid after release is position (0,0).
- Top word latency: wr_en rises the cycle after the odd-x block is sampled.
- Bottom word latency: at least 2 cycles after the odd-x block is sampled, because the pop is decided on the registered FIFO state.
- With continuous in_valid, FIFO occupancy never exceeds 1 and the output port carries one word per cycle.
- Gaps in in_valid do not disturb pairing. h1..h4 persist until the odd partner arrives.
- All outputs are registered. When wr_en=0, wr_data and wr_addr hold their last values.

## Configuration
- SR_WR_CLAMP_EN defined: every pixel byte with its sign bit set is replaced by 0x00 before packing into top and bottom words. Output is then in the range 0..127.
- SR_WR_CLAMP_EN undefined: bytes are packed unchanged as two's complement.
- The clamp is applied at capture and affects no timing.

## Structure
- Package sr_wr_pkg holds:
  - the PIX_W=8 and WORD_W=32 constants;
  - a packed typedef for a FIFO entry {addr, data};
  - a function computing AW from WIDTH and HEIGHT.
- Sub-module sr_wr_fifo: a synchronous FIFO parameterised by DEPTH and entry width. It provides push, pop, full, empty, dout (show-ahead) and resets on active-low rst.
- The top level contains the counters, holding registers, packing, clamp, the output mux/arbiter and the flags.

## Test plan
- Reset check: hold rst=0 for 3 cycles with in_valid=1 -> wr_en=0, wr_addr=0, wr_data=0, frame_done=0, ovf=0.
- Single pair at (0,0): in=(1,2,3,4) then (5,6,7,8) -> wr_data=0x06050201 @ addr 0, then 0x08070403 @ addr 57 one or more cycles later.
- Continuous frame of 19608 blocks with a ramp pattern -> each address 0..19607 written exactly once with matching data. FIFO occupancy never exceeds 1. ovf=0. frame_done fires exactly once, with addr 19607.
- Random in_valid gaps of 0-5 cycles over two frames -> data and address checks still pass. Frame two restarts at addr 0.
- rst=0 asserted mid-row at (37,10), then a restart -> no stale FIFO words appear. The first output word after restart has addr 0.
- With SR_WR_CLAMP_EN: in1=-5, in2=100 paired with (-128, 127) -> top word 0x7F006400. Without the macro, the same stimulus gives 0x7F8064FB.
